// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
//   arb_state_t : arbiter state (IDLE between grants, GRANT while a requester owns the port)
//   gid_w()     : width of a requester index
//   cnt_w()     : width of a burst counter able to hold 0..max_burst without wrapping
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic int gid_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int max_burst);
    return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
//   i_req   : request vector, one bit per requester
//   i_ptr   : index with highest priority; priority falls off cyclically above it
//   o_found : at least one request bit is set
//   o_idx   : first requesting index at or after i_ptr (mod NREQ); 0 when none
module rr_pick
  #(
    parameter int NREQ  = 4,
    parameter int GID_W = 2
  )
  (
    input  logic [NREQ-1:0]  i_req,
    input  logic [GID_W-1:0] i_ptr,
    output logic             o_found,
    output logic [GID_W-1:0] o_idx
  );

  // Offsets are scanned from farthest to nearest so the nearest hit is the
  // last assignment and therefore wins.
  always_comb begin
    int unsigned c;
    o_found = 1'b0;
    o_idx   = '0;
    c       = 0;
    for (int unsigned k = NREQ; k > 0; k--) begin
      c = 32'(i_ptr) + k - 1;
      if (c >= NREQ) c = c - NREQ;
      if (i_req[c]) begin
        o_found = 1'b1;
        o_idx   = GID_W'(c);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the dual-clock FIFO write port among NREQ
// requesters in the wr_clk domain, with bursts bounded to MAX_BURST words and
// back-pressure from the FIFO full flag.
//   wr_clk, rstn  : write clock, asynchronous active-low reset
//   req_valid     : per-requester word available
//   req_last      : per-requester last word of packet
//   req_data      : packed data, slice i = [i*DWIDTH +: DWIDTH]
//   req_ready     : per-requester word accepted this cycle (one-hot or zero)
//   fifo_full     : FIFO full flag
//   fifo_wr_en    : FIFO write strobe
//   fifo_data_in  : FIFO write data (slice of the grant holder)
//   grant_id      : current grant holder, meaningful while busy
//   busy          : a grant is active
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
  #(
    parameter  int NREQ      = 4,
    parameter  int DWIDTH    = 16,
    parameter  int MAX_BURST = 4,
    localparam int GID_W     = gid_w(NREQ),
    localparam int CNT_W     = cnt_w(MAX_BURST)
  )
  (
    input  logic                   wr_clk,
    input  logic                   rstn,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_last,
    input  logic [NREQ*DWIDTH-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    input  logic                   fifo_full,
    output logic                   fifo_wr_en,
    output logic [DWIDTH-1:0]      fifo_data_in,
    output logic [GID_W-1:0]       grant_id,
    output logic                   busy
  );

  arb_state_t       r_state, w_state_nxt;
  logic [GID_W-1:0] r_gid, w_gid_nxt;
  logic [GID_W-1:0] r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic             w_found;
  logic [GID_W-1:0] w_pick;
  logic             w_sel_valid;
  logic             w_sel_last;
  logic             w_xfer;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [GID_W-1:0] w_gid_next_rr;
  logic [NREQ-1:0]  w_ready;
  logic [DWIDTH-1:0] w_data;

  rr_pick #(.NREQ(NREQ), .GID_W(GID_W)) u_rr_pick (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  assign w_sel_valid   = req_valid[r_gid];
  assign w_sel_last    = req_last[r_gid];
  assign w_xfer        = (r_state == GRANT) && w_sel_valid && !fifo_full;
  assign w_cnt_inc     = r_cnt + 1'b1;
  assign w_gid_next_rr = (r_gid == GID_W'(NREQ - 1)) ? '0 : r_gid + 1'b1;

  always_comb begin
    w_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (r_gid == GID_W'(i)) w_data = req_data[i*DWIDTH +: DWIDTH];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gid_nxt   = r_gid;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_ready     = '0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_gid_nxt   = w_pick;
          w_cnt_nxt   = '0;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (w_xfer) w_ready[r_gid] = 1'b1;
        // A gap in the holder's valid releases without a transfer; a stall on
        // full keeps the grant and the count untouched.
        if (!w_sel_valid ||
            (w_xfer && (w_sel_last || (w_cnt_inc == CNT_W'(MAX_BURST))))) begin
          w_ptr_nxt   = w_gid_next_rr;
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else if (w_xfer) begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_gid   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gid   <= w_gid_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign fifo_wr_en   = w_xfer;
  assign req_ready    = w_ready;
  assign fifo_data_in = w_data;
  assign grant_id     = r_gid;
  assign busy         = (r_state == GRANT);

  // Requesters must hold valid, last and data until their word is accepted.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_proto
    a_hold: assert property (@(posedge wr_clk) disable iff (!rstn)
      (req_valid[gi] && !req_ready[gi]) |=>
        (req_valid[gi] && $stable(req_last[gi]) &&
         $stable(req_data[gi*DWIDTH +: DWIDTH])));
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int MB   = 4;
  localparam int GW   = 2;
  localparam int INF  = 1 << 30;

  logic              wr_clk = 1'b0;
  logic              rstn   = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_last  = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              fifo_full = 1'b0;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_data_in;
  logic [GW-1:0]     grant_id;
  logic              busy;

  always #5 wr_clk = ~wr_clk;

  fifo_wr_arbiter #(.NREQ(NREQ), .DWIDTH(DW), .MAX_BURST(MB)) dut (
    .wr_clk       (wr_clk),
    .rstn         (rstn),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: arbiter behaviour from the rules, in plain integers.
  bit m_busy;
  int m_gid, m_ptr, m_cnt;

  // Requester sources: words left to send, last-on-final-word flag, sequence.
  int         src_words[NREQ];
  bit         src_last[NREQ];
  logic [11:0] seq[NREQ];
  logic [11:0] sb_next[NREQ];
  int         wait_g[NREQ];

  int          g_log[$];
  int          g_words[$];
  logic [DW-1:0] w_log[$];
  bit          prev_busy;
  logic [NREQ-1:0] act_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = (src_words[i] > 0);
      req_last[i]  = src_last[i] && (src_words[i] == 1);
      req_data[i*DW +: DW] = {4'(i + 1), seq[i]};
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_gid = 0; m_ptr = 0; m_cnt = 0;
    prev_busy = 0;
    for (int i = 0; i < NREQ; i++) wait_g[i] = 0;
    g_log.delete(); g_words.delete(); w_log.delete();
  endtask

  task automatic model_step();
    int j;
    if (!m_busy) begin
      j = -1;
      for (int k = 0; k < NREQ; k++)
        if (j < 0 && req_valid[(m_ptr + k) % NREQ]) j = (m_ptr + k) % NREQ;
      if (j >= 0) begin
        m_busy = 1; m_gid = j; m_cnt = 0;
      end
    end else if (!req_valid[m_gid]) begin
      m_ptr = (m_gid + 1) % NREQ; m_busy = 0; m_cnt = 0;
    end else if (!fifo_full) begin
      m_cnt++;
      if (req_last[m_gid] || m_cnt == MB) begin
        m_ptr = (m_gid + 1) % NREQ; m_busy = 0; m_cnt = 0;
      end
    end
  endtask

  // One clock: drive inputs, check at the falling edge, advance at the rising edge.
  task automatic tick();
    logic            exp_wr;
    logic [NREQ-1:0] exp_rdy;
    logic [DW-1:0]   exp_data;
    int              id;
    drive();
    exp_wr = 1'b0; exp_rdy = '0; exp_data = '0;
    if (m_busy) begin
      exp_data = req_data[m_gid*DW +: DW];
      if (req_valid[m_gid] && !fifo_full) begin
        exp_wr = 1'b1;
        exp_rdy[m_gid] = 1'b1;
      end
    end
    @(negedge wr_clk);
    chk("busy", busy, m_busy);
    if (m_busy) chk("grant_id", grant_id, m_gid);
    chk("wr_en", fifo_wr_en, exp_wr);
    chk("ready", req_ready, exp_rdy);
    if (exp_wr) chk("data", fifo_data_in, exp_data);
    if (busy && !prev_busy) begin
      for (int i = 0; i < NREQ; i++)
        if (i != int'(grant_id)) wait_g[i] = req_valid[i] ? wait_g[i] + 1 : 0;
      chk("starve", (wait_g[grant_id] < NREQ), 1);
      wait_g[grant_id] = 0;
      g_log.push_back(int'(grant_id));
      g_words.push_back(0);
    end
    prev_busy = busy;
    if (fifo_wr_en) begin
      chk("no_wr_full", fifo_full, 0);
      id = int'(fifo_data_in[15:12]) - 1;
      chk("wr_id_range", (id >= 0 && id < NREQ), 1);
      if (id >= 0 && id < NREQ) begin
        chk("order", fifo_data_in[11:0], sb_next[id]);
        sb_next[id] = fifo_data_in[11:0] + 12'd1;
      end
      w_log.push_back(fifo_data_in);
      if (g_words.size() > 0) g_words[g_words.size()-1]++;
    end
    act_ready = req_ready;
    @(posedge wr_clk);
    model_step();
    #1;
    for (int i = 0; i < NREQ; i++)
      if (act_ready[i]) begin
        seq[i]++;
        src_words[i]--;
      end
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_grant_id", grant_id, 0);
    for (int i = 0; i < NREQ; i++) begin
      src_words[i] = 0; src_last[i] = 0;
    end
    fifo_full = 1'b0;
    drive();
    model_reset();
    repeat (2) @(posedge wr_clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      seq[i] = 12'h000; sb_next[i] = 12'h000;
    end
    seq[0] = 12'h111; sb_next[0] = 12'h111;
    #3;
    apply_reset();

    // Single word from requester 0
    src_words[0] = 1; src_last[0] = 1;
    repeat (4) tick();
    chk("t1_writes", w_log.size(), 1);
    chk("t1_word", w_log[0], 16'h1111);
    chk("t1_grant", g_log[0], 0);
    chk("t1_idle", busy, 0);

    // All requesters continuously valid: bursts of MB, order 0,1,2,3,0
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin src_words[i] = INF; src_last[i] = 0; end
    repeat (25) tick();
    chk("t2_ngrants", g_log.size(), 5);
    for (int k = 0; k < 5; k++) begin
      chk("t2_order", g_log[k], k % NREQ);
      chk("t2_burst", g_words[k], MB);
    end

    // Full stall mid-burst on requester 2
    apply_reset();
    src_words[2] = INF;
    repeat (3) tick();
    fifo_full = 1'b1;
    repeat (5) tick();
    chk("t3_stall_words", g_words[0], 2);
    chk("t3_held_busy", busy, 1);
    chk("t3_held_gid", grant_id, 2);
    fifo_full = 1'b0;
    repeat (3) tick();
    chk("t3_burst", g_words[0], MB);
    chk("t3_grants", g_log.size(), 1);

    // Requester 1 gaps after 2 words; next grant wraps to 0
    apply_reset();
    src_words[1] = 2; src_last[1] = 0;
    tick();
    src_words[0] = 1; src_last[0] = 1;
    repeat (6) tick();
    chk("t4_ngrants", g_log.size(), 2);
    chk("t4_first", g_log[0], 1);
    chk("t4_first_words", g_words[0], 2);
    chk("t4_second", g_log[1], 0);
    chk("t4_second_words", g_words[1], 1);

    // Reset in the middle of a burst, then arbitration restarts from 0
    apply_reset();
    src_words[1] = INF;
    repeat (4) tick();
    chk("t5_pre_busy", busy, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("t5_async_wr_en", fifo_wr_en, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_ready", req_ready, 0);
    model_reset();
    src_words[3] = INF;
    drive();
    @(posedge wr_clk);
    #1;
    rstn = 1'b1;
    repeat (12) tick();
    chk("t5_restart", g_log[0], 1);
    chk("t5_next", g_log[1], 3);

    // Random traffic and back-pressure
    apply_reset();
    repeat (8000) begin
      for (int i = 0; i < NREQ; i++)
        if (src_words[i] == 0 && $urandom_range(0, 7) == 0) begin
          src_words[i] = int'($urandom_range(1, 6));
          src_last[i]  = 1'($urandom_range(0, 1));
        end
      fifo_full = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
